// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and helpers for the locking register file
package regfile_pkg;
  typedef enum logic {RF_SRC_ALU = 1'b0, RF_SRC_LSU = 1'b1} rf_src_e;
  localparam int RF_ZERO_ADDR = 0;
  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction
endpackage

// File: rtl/regfile_lock_if.sv
// regfile_lock_if: read ports, write port, lock port and scoreboard view
interface regfile_lock_if import regfile_pkg::*; #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 5,
  parameter int NumRead = 2
) ();
  localparam int NumWords = 2**AddrWidth;
  logic [NumRead-1:0] rreq, rgnt, rvalid;
  logic [NumRead*AddrWidth-1:0] raddr;
  logic [NumRead*DataWidth-1:0] rdata;
  logic we;
  logic [AddrWidth-1:0] waddr;
  logic [DataWidth-1:0] wdata_alu, wdata_lsu;
  rf_src_e wsel;
  logic lock_req, lock_gnt;
  logic [AddrWidth-1:0] lock_addr;
  logic [NumWords-1:0] busy;
  modport master (
    output rreq, raddr, we, waddr, wdata_alu, wdata_lsu, wsel, lock_req, lock_addr,
    input rgnt, rvalid, rdata, lock_gnt, busy
  );
  modport slave (
    input rreq, raddr, we, waddr, wdata_alu, wdata_lsu, wsel, lock_req, lock_addr,
    output rgnt, rvalid, rdata, lock_gnt, busy
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy flags with lock grant and per-port busy lookup
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int AddrWidth = 5,
  parameter int NumRead = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         we,
  input  logic [AddrWidth-1:0]         waddr,
  input  logic                         lock_req,
  input  logic [AddrWidth-1:0]         lock_addr,
  input  logic [NumRead*AddrWidth-1:0] raddr,
  output logic                         lock_gnt,
  output logic [NumRead-1:0]           rbusy,
  output logic [2**AddrWidth-1:0]      busy
);
  localparam int NumWords = 2**AddrWidth;
  localparam logic [AddrWidth-1:0] zero_addr = AddrWidth'(RF_ZERO_ADDR);
  logic [NumWords-1:0] busy_q, busy_d;
  assign lock_gnt = lock_req && (!busy_q[lock_addr] || (we && waddr == lock_addr));
  assign busy = busy_q;
  always_comb begin
    rbusy = '0;
    for (int k = 0; k < NumRead; k++) rbusy[k] = busy_q[raddr[slice_lo(k, AddrWidth) +: AddrWidth]];
  end
  // set after clear so a lock granted alongside a write to the same register wins
  always_comb begin
    busy_d = busy_q;
    if (we) busy_d[waddr] = 1'b0;
    if (lock_gnt && lock_addr != zero_addr) busy_d[lock_addr] = 1'b1;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) busy_q <= '0;
    else busy_q <= busy_d;
endmodule

// File: rtl/regfile_lock.sv
// regfile_lock: clocked multi-port register file with lock scoreboard and write forwarding
module regfile_lock import regfile_pkg::*; #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 5,
  parameter int NumRead = 2,
  parameter int WriteForward = 1
) (
  input logic clk_i,
  input logic rst_ni,
  regfile_lock_if.slave bus
);
  localparam int NumWords = 2**AddrWidth;
  localparam logic [AddrWidth-1:0] zero_addr = AddrWidth'(RF_ZERO_ADDR);
  logic [DataWidth-1:0] mem [NumWords];
  logic [DataWidth-1:0] wdata;
  logic [AddrWidth-1:0] ra [NumRead];
  logic [NumRead-1:0] fwd, gnt, rbusy, rvalid_q;
  logic [DataWidth-1:0] rdata_q [NumRead];
  assign wdata = bus.wsel == RF_SRC_LSU ? bus.wdata_lsu : bus.wdata_alu;
  regfile_scoreboard #(.AddrWidth(AddrWidth), .NumRead(NumRead)) u_sb (
    .clk_i,
    .rst_ni,
    .we(bus.we),
    .waddr(bus.waddr),
    .lock_req(bus.lock_req),
    .lock_addr(bus.lock_addr),
    .raddr(bus.raddr),
    .lock_gnt(bus.lock_gnt),
    .rbusy,
    .busy(bus.busy)
  );
  // x0 never forwards, so its reads always come from the never-written mem[0]
  always_comb begin
    fwd = '0;
    gnt = '0;
    for (int k = 0; k < NumRead; k++) begin
      ra[k] = bus.raddr[slice_lo(k, AddrWidth) +: AddrWidth];
      fwd[k] = WriteForward != 0 && bus.we && bus.waddr == ra[k] && ra[k] != zero_addr;
      gnt[k] = bus.rreq[k] && (!rbusy[k] || fwd[k]);
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) for (int i = 0; i < NumWords; i++) mem[i] <= '0;
    else if (bus.we && bus.waddr != zero_addr) mem[bus.waddr] <= wdata;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      rvalid_q <= '0;
      for (int k = 0; k < NumRead; k++) rdata_q[k] <= '0;
    end else begin
      rvalid_q <= gnt;
      for (int k = 0; k < NumRead; k++) if (gnt[k]) rdata_q[k] <= fwd[k] ? wdata : mem[ra[k]];
    end
  always_comb begin
    bus.rgnt = gnt;
    bus.rvalid = rvalid_q;
    bus.rdata = '0;
    for (int k = 0; k < NumRead; k++) bus.rdata[slice_lo(k, DataWidth) +: DataWidth] = rdata_q[k];
  end
endmodule

// File: tb/tb_regfile_lock.sv
// tb_regfile_lock: directed vector table plus hand sequences for forwarding-off and async reset
module tb_regfile_lock import regfile_pkg::*;;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  regfile_lock_if #(.DataWidth(32), .AddrWidth(5), .NumRead(2)) b0 ();
  regfile_lock_if #(.DataWidth(32), .AddrWidth(5), .NumRead(2)) b1 ();
  regfile_lock #(.DataWidth(32), .AddrWidth(5), .NumRead(2), .WriteForward(1)) u0 (.clk_i(clk), .rst_ni(rst_n), .bus(b0));
  regfile_lock #(.DataWidth(32), .AddrWidth(5), .NumRead(2), .WriteForward(0)) u1 (.clk_i(clk), .rst_ni(rst_n), .bus(b1));
  typedef struct {
    logic [1:0] rreq; logic [4:0] ra0, ra1;
    logic we; logic [4:0] wa; logic [31:0] wd; logic wsel;
    logic lreq; logic [4:0] la;
    logic [1:0] e_gnt; logic e_lgnt; logic [31:0] e_d0, e_d1; logic [4:0] ba; logic e_busy;
  } vec_t;
  vec_t vt [16];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask
  task automatic idle0();
    b0.rreq = '0; b0.raddr = '0; b0.we = 0; b0.waddr = '0; b0.wdata_alu = '0; b0.wdata_lsu = '0;
    b0.wsel = RF_SRC_ALU; b0.lock_req = 0; b0.lock_addr = '0;
  endtask
  task automatic idle1();
    b1.rreq = '0; b1.raddr = '0; b1.we = 0; b1.waddr = '0; b1.wdata_alu = '0; b1.wdata_lsu = '0;
    b1.wsel = RF_SRC_ALU; b1.lock_req = 0; b1.lock_addr = '0;
  endtask
  initial begin
    //          rreq  ra0 ra1 we wa  wd            wsel lreq la  gnt   lgnt d0            d1            ba  busy
    vt[0]  = '{2'b01, 5,  0,  0, 0,  32'h0,        0,   0,   0,  2'b01, 0,  32'h0,        32'h0,        5,  0};
    vt[1]  = '{2'b00, 0,  0,  1, 3,  32'hDEADBEEF, 0,   0,   0,  2'b00, 0,  32'h0,        32'h0,        3,  0};
    vt[2]  = '{2'b11, 3,  3,  0, 0,  32'h0,        0,   0,   0,  2'b11, 0,  32'hDEADBEEF, 32'hDEADBEEF, 3,  0};
    vt[3]  = '{2'b11, 0,  0,  1, 0,  32'h1234,     0,   0,   0,  2'b11, 0,  32'h0,        32'h0,        0,  0};
    vt[4]  = '{2'b11, 0,  0,  0, 0,  32'h0,        0,   0,   0,  2'b11, 0,  32'h0,        32'h0,        0,  0};
    vt[5]  = '{2'b00, 0,  0,  0, 0,  32'h0,        0,   1,   7,  2'b00, 1,  32'h0,        32'h0,        7,  1};
    vt[6]  = '{2'b01, 7,  0,  0, 0,  32'h0,        0,   0,   0,  2'b00, 0,  32'h0,        32'h0,        7,  1};
    vt[7]  = '{2'b01, 7,  0,  0, 0,  32'h0,        0,   0,   0,  2'b00, 0,  32'h0,        32'h0,        7,  1};
    vt[8]  = '{2'b11, 7,  3,  1, 7,  32'hCAFE0001, 1,   0,   0,  2'b11, 0,  32'hCAFE0001, 32'hDEADBEEF, 7,  0};
    vt[9]  = '{2'b00, 0,  0,  0, 0,  32'h0,        0,   1,   7,  2'b00, 1,  32'h0,        32'h0,        7,  1};
    vt[10] = '{2'b00, 0,  0,  0, 0,  32'h0,        0,   1,   7,  2'b00, 0,  32'h0,        32'h0,        7,  1};
    vt[11] = '{2'b01, 7,  0,  1, 7,  32'h11,       0,   1,   7,  2'b01, 1,  32'h11,       32'h0,        7,  1};
    vt[12] = '{2'b00, 0,  0,  0, 0,  32'h0,        0,   1,   0,  2'b00, 1,  32'h0,        32'h0,        0,  0};
    vt[13] = '{2'b10, 0,  7,  1, 7,  32'h22,       1,   0,   0,  2'b10, 0,  32'h0,        32'h22,       7,  0};
    vt[14] = '{2'b01, 3,  0,  0, 0,  32'h0,        0,   1,   3,  2'b01, 1,  32'hDEADBEEF, 32'h0,        3,  1};
    vt[15] = '{2'b10, 0,  3,  1, 3,  32'h33,       0,   0,   0,  2'b10, 0,  32'h0,        32'h33,       3,  0};
    idle0();
    idle1();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", b0.busy, 32'h0);
    chk("reset_rvalid", {30'h0, b0.rvalid}, 32'h0);
    chk("reset_rdata0", b0.rdata[31:0], 32'h0);
    chk("reset_rdata1", b0.rdata[63:32], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      b0.rreq = vt[i].rreq;
      b0.raddr = {vt[i].ra1, vt[i].ra0};
      b0.we = vt[i].we;
      b0.waddr = vt[i].wa;
      b0.wsel = rf_src_e'(vt[i].wsel);
      b0.wdata_lsu = vt[i].wsel ? vt[i].wd : ~vt[i].wd;
      b0.wdata_alu = vt[i].wsel ? ~vt[i].wd : vt[i].wd;
      b0.lock_req = vt[i].lreq;
      b0.lock_addr = vt[i].la;
      #1;
      chk($sformatf("v%0d_rgnt", i), {30'h0, b0.rgnt}, {30'h0, vt[i].e_gnt});
      chk($sformatf("v%0d_lock_gnt", i), {31'h0, b0.lock_gnt}, {31'h0, vt[i].e_lgnt});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_rvalid", i), {30'h0, b0.rvalid}, {30'h0, vt[i].e_gnt});
      if (vt[i].e_gnt[0]) chk($sformatf("v%0d_rdata0", i), b0.rdata[31:0], vt[i].e_d0);
      if (vt[i].e_gnt[1]) chk($sformatf("v%0d_rdata1", i), b0.rdata[63:32], vt[i].e_d1);
      chk($sformatf("v%0d_busy", i), {31'h0, b0.busy[vt[i].ba]}, {31'h0, vt[i].e_busy});
    end
    idle0();
    // forwarding disabled: same-cycle write returns old data, then new data
    @(negedge clk);
    b1.we = 1; b1.waddr = 9; b1.wdata_alu = 32'h55; b1.wdata_lsu = 32'hAA;
    b1.rreq = 2'b01; b1.raddr = {5'd0, 5'd9};
    #1;
    chk("nofwd_rgnt", {30'h0, b1.rgnt}, 32'h1);
    @(posedge clk);
    #1;
    chk("nofwd_old", b1.rdata[31:0], 32'h0);
    @(negedge clk);
    b1.we = 0;
    @(posedge clk);
    #1;
    chk("nofwd_new", b1.rdata[31:0], 32'h55);
    @(negedge clk);
    b1.rreq = '0;
    @(posedge clk);
    #1;
    chk("nofwd_idle_rvalid", {30'h0, b1.rvalid}, 32'h0);
    chk("nofwd_hold", b1.rdata[31:0], 32'h55);
    // asynchronous reset between edges wipes locks and pending reads
    @(negedge clk);
    b0.lock_req = 1; b0.lock_addr = 4; b0.rreq = 2'b01; b0.raddr = {5'd0, 5'd3};
    @(posedge clk);
    #1;
    chk("prerst_busy4", {31'h0, b0.busy[4]}, 32'h1);
    chk("prerst_rvalid", {30'h0, b0.rvalid}, 32'h1);
    idle0();
    #1 rst_n = 1'b0;
    #1;
    chk("async_busy", b0.busy, 32'h0);
    chk("async_rvalid", {30'h0, b0.rvalid}, 32'h0);
    chk("async_rdata0", b0.rdata[31:0], 32'h0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    b0.rreq = 2'b11; b0.raddr = {5'd3, 5'd4};
    #1;
    chk("postrst_rgnt", {30'h0, b0.rgnt}, 32'h3);
    @(posedge clk);
    #1;
    chk("postrst_rvalid", {30'h0, b0.rvalid}, 32'h3);
    chk("postrst_x4", b0.rdata[31:0], 32'h0);
    chk("postrst_x3", b0.rdata[63:32], 32'h0);
    idle0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
